// File: rtl/image_receiver.sv
// UART (8N1) receive path that rebuilds 12-bit pixels from byte pairs (high nibble first)
// and writes them at sequential frame-buffer addresses, with idle timeouts for resync.
module image_receiver #(
    parameter int NUM_PIXELS    = 100,
    parameter int CLKS_PER_BIT  = 5208,
    parameter int BYTE_TIMEOUT  = 104160,
    parameter int FRAME_TIMEOUT = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_in,
    output logic [16:0] wr_addr,
    output logic [11:0] wr_data,
    output logic        wr_en,
    output logic        image_done,
    output logic        framing_error
);

    localparam int BIT_W  = $clog2(CLKS_PER_BIT) + 1;
    localparam int IDLE_W = $clog2(FRAME_TIMEOUT) + 1;

    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  HALF_LAST = BIT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDLE_W-1:0] BYTE_TO   = IDLE_W'(BYTE_TIMEOUT);
    localparam logic [IDLE_W-1:0] FRAME_TO  = IDLE_W'(FRAME_TIMEOUT);
    localparam logic [16:0]       ADDR_LAST = 17'(NUM_PIXELS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    function automatic logic [IDLE_W-1:0] sat_inc(input logic [IDLE_W-1:0] v);
        return (v >= FRAME_TO) ? FRAME_TO : v + 1'b1;
    endfunction

    rx_state_t         state;
    logic              sync_p0;
    logic              sync_p1;
    logic [BIT_W-1:0]  clk_cnt;
    logic [2:0]        bit_idx;
    logic [IDLE_W-1:0] idle_cnt;
    logic              phase_low;
    logic [7:0]        shift_p2;
    logic [3:0]        nibble_p2;
    logic              rx_line;
    logic              data_tick;
    logic              stop_tick;

    assign rx_line   = sync_p1;
    assign data_tick = (state == DATA) && (clk_cnt == BIT_LAST);
    assign stop_tick = (state == STOP) && (clk_cnt == BIT_LAST);

    // stage p0/p1: two-flop synchroniser, preset to the idle-high line level
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= uart_in;
            sync_p1 <= sync_p0;
        end
    end

    // stage p2: bit shifter and high-nibble holding register (pure datapath)
    always_ff @(posedge clk) begin
        if (data_tick)
            shift_p2 <= {rx_line, shift_p2[7:1]};
        if (stop_tick && rx_line && !phase_low)
            nibble_p2 <= shift_p2[3:0];
    end

    // stage p3: bit-timing FSM, pixel assembly, addressing and idle timeouts
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            clk_cnt       <= '0;
            bit_idx       <= '0;
            idle_cnt      <= '0;
            phase_low     <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
            wr_en         <= 1'b0;
            image_done    <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            wr_en         <= 1'b0;
            image_done    <= 1'b0;
            framing_error <= 1'b0;

            if (wr_en)
                wr_addr <= (wr_addr == ADDR_LAST) ? '0 : wr_addr + 17'd1;

            if (state == IDLE && rx_line)
                idle_cnt <= sat_inc(idle_cnt);
            else
                idle_cnt <= '0;

            // A long silence mid-pixel means the low byte was lost; resync on the next high byte.
            if (idle_cnt == BYTE_TO)
                phase_low <= 1'b0;
            if (idle_cnt == FRAME_TO) begin
                wr_addr   <= '0;
                phase_low <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!rx_line) begin
                        state   <= START;
                        clk_cnt <= '0;
                        bit_idx <= '0;
                    end
                end
                START: begin
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt <= '0;
                        state   <= rx_line ? IDLE : DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7)
                            state <= STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        state   <= IDLE;
                        if (!rx_line) begin
                            framing_error <= 1'b1;
                            phase_low     <= 1'b0;
                        end else if (phase_low) begin
                            wr_en      <= 1'b1;
                            wr_data    <= {nibble_p2, shift_p2};
                            image_done <= (wr_addr == ADDR_LAST);
                            phase_low  <= 1'b0;
                        end else begin
                            phase_low <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
